// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and PC defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        STALL    = 3'd3,
        DRAIN    = 3'd4
    } fetch_state_t;

    localparam int unsigned PC_STEP_DEF  = 4;
    localparam int unsigned RESET_PC_DEF = 0;

endpackage

// File: rtl/mux_2to1.sv
// Generic 2:1 bus select: sel=0 picks in_a, sel=1 picks in_b.
// Latency: combinational.
// Backpressure: none.
module mux_2to1 #(
    parameter int bus_size = 10
) (
    input  logic [bus_size-1:0] in_a,
    input  logic [bus_size-1:0] in_b,
    input  logic                sel,
    output logic [bus_size-1:0] out
);

    assign out = sel ? in_b : in_a;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, selects sequential/redirect next-PC, drains abandoned fetches.
// Latency: control outputs combinational from state/inputs; pc and state update on the clk edge.
// Backpressure: stall or mem_ready=0 hold the PC; fetch_req drops in STALL and DRAIN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          bus_size = 10,
    parameter int unsigned RESET_PC = RESET_PC_DEF,
    parameter int unsigned PC_STEP  = PC_STEP_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [bus_size-1:0] redirect_target,
    input  logic                mem_ready,
    output logic                fetch_req,
    output logic [bus_size-1:0] pc,
    output logic                pc_sel,
    output logic                pc_we,
    output logic                if_valid,
    output logic                flush,
    output logic [CNT_W-1:0]    stall_cnt
);

    fetch_state_t        state, state_nxt;
    logic [bus_size-1:0] pc_inc;
    logic [bus_size-1:0] pc_nxt;

    // Wraps silently at 2^bus_size.
    assign pc_inc = pc + bus_size'(PC_STEP);

    mux_2to1 #(.bus_size(bus_size)) u_pc_mux (
        .in_a (pc_inc),
        .in_b (redirect_target),
        .sel  (pc_sel),
        .out  (pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= bus_size'(RESET_PC);
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pc_we)
                pc <= pc_nxt;
            if (state == STALL && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        fetch_req = 1'b0;
        pc_sel    = 1'b0;
        pc_we     = 1'b0;
        if_valid  = 1'b0;
        flush     = 1'b0;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH, WAIT_MEM: begin
                fetch_req = 1'b1;
                if (redirect) begin
                    pc_sel = 1'b1;
                    pc_we  = 1'b1;
                    flush  = 1'b1;
                    // Abandoning an unanswered request in WAIT_MEM needs a drain.
                    state_nxt = (state == WAIT_MEM && !mem_ready) ? DRAIN : FETCH;
                end else if (stall) begin
                    state_nxt = STALL;
                end else if (mem_ready) begin
                    if_valid  = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = WAIT_MEM;
                end
            end
            STALL: begin
                if (redirect) begin
                    pc_sel    = 1'b1;
                    pc_we     = 1'b1;
                    flush     = 1'b1;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_sel = 1'b1;
                    pc_we  = 1'b1;
                    flush  = 1'b1;
                end
                // The stale response retires the drain even when a new redirect lands with it.
                if (mem_ready)
                    state_nxt = FETCH;
            end
            default: state_nxt = BOOT;
        endcase
        // Reset pre-empts any load or handshake in the same cycle.
        if (!rst_n) begin
            fetch_req = 1'b0;
            pc_sel    = 1'b0;
            pc_we     = 1'b0;
            if_valid  = 1'b0;
            flush     = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic against a flag-based reference model.
module tb_fetch_sequencer;

    localparam int BW    = 10;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [BW-1:0] redirect_target = '0;
    logic          mem_ready = 1'b0;
    logic          fetch_req, pc_sel, pc_we, if_valid, flush;
    logic [BW-1:0] pc;
    logic [CW-1:0] stall_cnt;

    fetch_sequencer #(
        .bus_size (BW),
        .RESET_PC (0),
        .PC_STEP  (4),
        .CNT_W    (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .mem_ready       (mem_ready),
        .fetch_req       (fetch_req),
        .pc              (pc),
        .pc_sel          (pc_sel),
        .pc_we           (pc_we),
        .if_valid        (if_valid),
        .flush           (flush),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            chk;
        logic [4:0]    ctl;   // {fetch_req, pc_sel, pc_we, if_valid, flush}
        logic [BW-1:0] pc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: fetch-stage condition flags instead of a state number.
    bit            m_boot = 1'b1;
    bit            m_stalled, m_waiting, m_draining;
    logic [BW-1:0] m_pc = '0;
    int            m_cnt = 0;

    task automatic step(input bit st, input bit rd, input logic [BW-1:0] tgt,
                        input bit mr, input bit rn, input bit chk);
        exp_t e;
        bit   req, take, acc;
        @(posedge clk);
        #1;
        stall = st; redirect = rd; redirect_target = tgt; mem_ready = mr; rst_n = rn;
        req  = !m_boot && !m_stalled && !m_draining;
        take = !m_boot && rd;
        acc  = req && !rd && !st && mr;
        e.chk = chk;
        e.pc  = m_pc;
        e.cnt = CW'(m_cnt);
        e.ctl = rn ? {req, take, take || acc, acc, take} : 5'b0;
        exp_q.push_back(e);
        if (!rn) begin
            m_boot = 1; m_stalled = 0; m_waiting = 0; m_draining = 0;
            m_pc = '0; m_cnt = 0;
        end else begin
            if (m_stalled && m_cnt < CMAX) m_cnt++;
            if (m_boot) begin
                m_boot = 0;
            end else if (rd) begin
                m_pc = tgt;
                m_draining = (m_waiting || m_draining) && !mr;
                m_waiting = 0; m_stalled = 0;
            end else if (req && st) begin
                m_stalled = 1; m_waiting = 0;
            end else if (req && mr) begin
                m_pc = m_pc + BW'(4); m_waiting = 0;
            end else if (req) begin
                m_waiting = 1;
            end else if (m_stalled) begin
                m_stalled = st;
            end else if (m_draining) begin
                m_draining = !mr;
            end
        end
    endtask

    task automatic run(input int n, input bit mr);
        for (int i = 0; i < n; i++) step(0, 0, '0, mr, 1, 1);
    endtask

    // Monitor: pops one expectation per presented cycle and compares mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                checks++;
                if (pc !== e.pc) begin
                    errors++;
                    $display("FAIL pc: got %h expected %h at %0t", pc, e.pc, $time);
                end
                checks++;
                if ({fetch_req, pc_sel, pc_we, if_valid, flush} !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl{req,sel,we,iv,fl}: got %b expected %b at %0t",
                             {fetch_req, pc_sel, pc_we, if_valid, flush}, e.ctl, $time);
                end
                checks++;
                if (stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt: got %0d expected %0d at %0t", stall_cnt, e.cnt, $time);
                end
                checks++;
                if (if_valid === 1'b1 && flush === 1'b1) begin
                    errors++;
                    $display("FAIL iv_flush_excl: got both 1 expected not both at %0t", $time);
                end
            end
        end
    end

    initial begin
        step(0, 0, '0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 1);            // reset state
        run(3, 1);                          // BOOT, pc 0, 4
        run(3, 0);                          // wait states at pc 8
        run(2, 1);                          // pc 8 accepted, C accepted
        step(1, 0, '0, 1, 1, 1);            // stall at pc 10
        for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 1, 1);
        step(0, 0, '0, 1, 1, 1);            // leave STALL, cnt reaches 4
        run(2, 1);
        step(1, 1, 10'h040, 1, 1, 1);       // redirect beats stall
        run(2, 1);
        step(0, 1, 10'h3F8, 0, 1, 1);       // preload near top for wrap
        run(4, 1);
        step(0, 0, '0, 0, 1, 1);            // into WAIT_MEM
        step(0, 1, 10'h080, 0, 1, 1);       // -> DRAIN
        step(0, 0, '0, 0, 1, 1);
        step(0, 0, '0, 1, 1, 1);            // late data discarded
        run(2, 1);
        step(0, 0, '0, 0, 1, 1);
        step(0, 1, 10'h100, 0, 1, 1);
        step(0, 1, 10'h0C0, 0, 1, 1);       // second redirect inside DRAIN
        step(0, 0, '0, 1, 1, 1);
        run(2, 1);
        step(0, 0, '0, 0, 1, 1);
        step(0, 1, 10'h200, 0, 1, 1);       // into DRAIN again
        step(0, 0, '0, 0, 0, 1);            // reset while draining
        run(3, 1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                 BW'($urandom), $urandom_range(0, 99) < 60,
                 $urandom_range(0, 199) != 0, 1);
        end
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
